// File: rtl/affine_mv_ctrl_pkg.sv
// ==== affine_pkg : shared types and constants for the affine CPMV controller == rev 1.0 ====
`default_nettype none

package affine_pkg;

  localparam int MV_W_DEF  = 16;
  localparam int CP_NUM_4P = 2;
  localparam int CP_NUM_6P = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  // Index of the final CPMV of an operation in the given mode
  function automatic logic [1:0] cp_last(input logic mode_6p);
    return mode_6p ? 2'(CP_NUM_6P - 1) : 2'(CP_NUM_4P - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/affine_mv_ctrl_if.sv
// ==== affine_mv_ctrl_if : CPMV stream, calculator handshake and write bus == rev 1.0 ====
`default_nettype none

interface affine_mv_ctrl_if
  import affine_pkg::*;
#(
  parameter int MV_W = MV_W_DEF
);
  logic            MODE_6P;
  logic            MV_VALID;
  logic [MV_W-1:0] MV_DATA;
  logic            MV_READY;
  logic            ABORT;
  logic            CALC_DONE;
  logic [MV_W-1:0] WR_DATA;
  logic [2:0]      WE_CP;
  logic            MODE_OUT;
  logic            START;
  logic            BUSY;
  logic            DONE;
  logic            ERR;

  modport master (
    output MODE_6P, MV_VALID, MV_DATA, ABORT, CALC_DONE,
    input  MV_READY, WR_DATA, WE_CP, MODE_OUT, START, BUSY, DONE, ERR
  );

  modport slave (
    input  MODE_6P, MV_VALID, MV_DATA, ABORT, CALC_DONE,
    output MV_READY, WR_DATA, WE_CP, MODE_OUT, START, BUSY, DONE, ERR
  );
endinterface

`default_nettype wire

// File: rtl/affine_mv_ctrl_watchdog.sv
// ==== mv_watchdog : WAIT-state cycle counter with clear, enable and expiry == rev 1.0 ====
`default_nettype none

module mv_watchdog
  import affine_pkg::*;
#(
  parameter int TIMEOUT = 1023
) (
  input  wire logic CLK,
  input  wire logic RST_ASYNC_N,
  input  wire logic clr_i,
  input  wire logic en_i,
  output logic      exp_o
);
  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign cnt_d = cnt_q + CW'(1);
  // Expires on the enabled cycle whose increment brings the count to TIMEOUT
  assign exp_o = en_i && (cnt_d == LIMIT);

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/affine_mv_ctrl.sv
// ==== affine_mv_ctrl : steers 2/3 CPMVs into the CPMV bank, then starts and ==
// ==== supervises the affine calculator                              rev 1.0 ====
`default_nettype none

module affine_mv_ctrl
  import affine_pkg::*;
#(
  parameter int MV_W    = MV_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input wire logic         CLK,
  input wire logic         RST_ASYNC_N,
  affine_mv_ctrl_if.slave  bus
);
  state_t          state_q;
  logic [1:0]      idx_q;
  logic [MV_W-1:0] wr_data_q;
  logic [2:0]      we_cp_q;
  logic            mode_q;
  logic            start_q;
  logic            done_q;
  logic            err_q;

  logic hs;
  logic wd_clr;
  logic wd_en;
  logic wd_exp;

  assign bus.MV_READY = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign hs           = bus.MV_VALID && bus.MV_READY;

  assign bus.WR_DATA  = wr_data_q;
  assign bus.WE_CP    = we_cp_q;
  assign bus.MODE_OUT = mode_q;
  assign bus.START    = start_q;
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;

  // CALC_DONE and ABORT both outrank the watchdog in the same cycle
  assign wd_clr = (state_q == ST_START);
  assign wd_en  = (state_q == ST_WAIT) && !bus.CALC_DONE && !bus.ABORT;

  mv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .clr_i       (wd_clr),
    .en_i        (wd_en),
    .exp_o       (wd_exp)
  );

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      wr_data_q <= '0;
      we_cp_q   <= 3'b000;
      mode_q    <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_cp_q <= 3'b000;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (bus.ABORT) begin
        state_q <= ST_IDLE;
        idx_q   <= 2'd0;
      end else begin
        if (hs) begin
          wr_data_q <= bus.MV_DATA;
          we_cp_q   <= 3'b001 << idx_q;
          idx_q     <= idx_q + 2'd1;
        end
        case (state_q)
          ST_IDLE: begin
            if (hs) begin
              mode_q  <= bus.MODE_6P;
              state_q <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (hs && (idx_q == cp_last(mode_q))) begin
              state_q <= ST_FLUSH;
            end
          end
          // START is registered, so it is raised on the way into ST_START
          ST_FLUSH: begin
            start_q <= 1'b1;
            state_q <= ST_START;
          end
          ST_START: begin
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (bus.CALC_DONE) begin
              done_q  <= 1'b1;
              idx_q   <= 2'd0;
              state_q <= ST_IDLE;
            end else if (wd_exp) begin
              err_q   <= 1'b1;
              idx_q   <= 2'd0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            idx_q   <= 2'd0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_affine_mv_ctrl.sv
// ==== tb_affine_mv_ctrl : directed vector table plus hand-written corner sequences == rev 1.0 ====
`default_nettype none

module tb_affine_mv_ctrl;
  logic CLK;
  logic RST_ASYNC_N;
  int   checks;
  int   errors;

  affine_mv_ctrl_if #(.MV_W(16)) bus ();

  affine_mv_ctrl #(
    .MV_W    (16),
    .TIMEOUT (8)
  ) dut (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .bus         (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        vld;
    logic [15:0] data;
    logic        m6;
    logic        abt;
    logic        cdn;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  // Expected outputs packed as {pad, READY, WR_DATA, WE_CP, MODE_OUT, START, BUSY, DONE, ERR}
  function automatic vec_t v(input logic vld, input logic [15:0] d, input logic m6,
                             input logic abt, input logic cdn, input logic rdy,
                             input logic [15:0] wd, input logic [2:0] we, input logic mo,
                             input logic st, input logic bsy, input logic dn, input logic er);
    vec_t r;
    r.vld  = vld;
    r.data = d;
    r.m6   = m6;
    r.abt  = abt;
    r.cdn  = cdn;
    r.exp  = {7'd0, rdy, wd, we, mo, st, bsy, dn, er};
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return {7'd0, bus.MV_READY, bus.WR_DATA, bus.WE_CP, bus.MODE_OUT,
            bus.START, bus.BUSY, bus.DONE, bus.ERR};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [15:0] d, input logic m6,
                       input logic abt, input logic cdn);
    bus.MV_VALID  = vld;
    bus.MV_DATA   = d;
    bus.MODE_6P   = m6;
    bus.ABORT     = abt;
    bus.CALC_DONE = cdn;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    //        vld data      m6 ab cd | rdy wr_data   we      mo st bs dn er
    // 6P back-to-back, CALC_DONE in the second WAIT cycle
    tbl[0]  = v(1, 16'h0102, 1, 0, 0,  1, 16'h0000, 3'b000, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 16'hFF80, 1, 0, 0,  1, 16'h0102, 3'b001, 1, 0, 1, 0, 0);
    tbl[2]  = v(1, 16'h7F01, 1, 0, 0,  1, 16'hFF80, 3'b010, 1, 0, 1, 0, 0);
    tbl[3]  = v(0, 16'h0000, 1, 0, 0,  0, 16'h7F01, 3'b100, 1, 0, 1, 0, 0);
    tbl[4]  = v(0, 16'h0000, 0, 0, 0,  0, 16'h7F01, 3'b000, 1, 1, 1, 0, 0);
    tbl[5]  = v(0, 16'h0000, 0, 0, 0,  0, 16'h7F01, 3'b000, 1, 0, 1, 0, 0);
    tbl[6]  = v(0, 16'h0000, 0, 0, 1,  0, 16'h7F01, 3'b000, 1, 0, 1, 0, 0);
    // 4P started in the DONE cycle, 3-cycle valid gap, MODE_6P flips mid-load
    tbl[7]  = v(1, 16'h0A0B, 0, 0, 0,  1, 16'h7F01, 3'b000, 1, 0, 0, 1, 0);
    tbl[8]  = v(0, 16'h0000, 0, 0, 0,  1, 16'h0A0B, 3'b001, 0, 0, 1, 0, 0);
    tbl[9]  = v(0, 16'h0000, 0, 0, 0,  1, 16'h0A0B, 3'b000, 0, 0, 1, 0, 0);
    tbl[10] = v(0, 16'h0000, 0, 0, 0,  1, 16'h0A0B, 3'b000, 0, 0, 1, 0, 0);
    tbl[11] = v(1, 16'hF5F6, 1, 0, 0,  1, 16'h0A0B, 3'b000, 0, 0, 1, 0, 0);
    tbl[12] = v(0, 16'h0000, 0, 0, 0,  0, 16'hF5F6, 3'b010, 0, 0, 1, 0, 0);
    // CALC_DONE during START is ignored, stray MV_VALID is not accepted
    tbl[13] = v(1, 16'h1234, 0, 0, 1,  0, 16'hF5F6, 3'b000, 0, 1, 1, 0, 0);
    tbl[14] = v(1, 16'h1234, 0, 0, 0,  0, 16'hF5F6, 3'b000, 0, 0, 1, 0, 0);
    tbl[15] = v(0, 16'h0000, 0, 0, 0,  0, 16'hF5F6, 3'b000, 0, 0, 1, 0, 0);
    tbl[16] = v(0, 16'h0000, 0, 0, 0,  0, 16'hF5F6, 3'b000, 0, 0, 1, 0, 0);
    tbl[17] = v(0, 16'h0000, 0, 0, 0,  0, 16'hF5F6, 3'b000, 0, 0, 1, 0, 0);
    tbl[18] = v(0, 16'h0000, 0, 0, 0,  0, 16'hF5F6, 3'b000, 0, 0, 1, 0, 0);
    tbl[19] = v(0, 16'h0000, 0, 0, 1,  0, 16'hF5F6, 3'b000, 0, 0, 1, 0, 0);
    tbl[20] = v(0, 16'h0000, 0, 0, 0,  1, 16'hF5F6, 3'b000, 0, 0, 0, 1, 0);
    tbl[21] = v(0, 16'h0000, 0, 0, 0,  1, 16'hF5F6, 3'b000, 0, 0, 0, 0, 0);

    RST_ASYNC_N = 1'b0;
    drive(0, 16'h0000, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_values", outs(), {7'd0, 1'b1, 16'h0000, 3'b000, 5'b00000});
    RST_ASYNC_N = 1'b1;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      drive(tbl[i].vld, tbl[i].data, tbl[i].m6, tbl[i].abt, tbl[i].cdn);
      cyc();
    end

    // Watchdog: 8 WAIT cycles, then ERR with BUSY low
    drive(1, 16'h1111, 0, 0, 0);
    cyc();
    drive(1, 16'h2222, 0, 0, 0);
    cyc();
    drive(0, 16'h0000, 0, 0, 0);
    cyc();
    chk("to_start", 32'(bus.START), 32'd1);
    cyc();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("to_wait%0d_busy_err", k), {30'd0, bus.BUSY, bus.ERR}, 32'b10);
      cyc();
    end
    chk("to_err_pulse", {29'd0, bus.ERR, bus.BUSY, bus.MV_READY}, 32'b101);
    cyc();
    chk("to_err_clear", {30'd0, bus.ERR, bus.BUSY}, 32'b00);

    // ABORT after 2 of 3 CPMVs, colliding with a third handshake
    drive(1, 16'h0001, 1, 0, 0);
    cyc();
    drive(1, 16'h0002, 1, 0, 0);
    cyc();
    chk("ab_we_second", {29'd0, bus.WE_CP}, 32'b010);
    drive(1, 16'h0003, 1, 1, 0);
    cyc();
    chk("ab_idle", {26'd0, bus.MV_READY, bus.BUSY, bus.WE_CP, bus.START}, {26'd0, 6'b100000});
    chk("ab_wr_hold", {16'd0, bus.WR_DATA}, 32'h0002);
    drive(0, 16'h0000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("ab_no_start%0d", k), {30'd0, bus.START, bus.BUSY}, 32'b00);
    end
    drive(1, 16'h0A0A, 0, 0, 0);
    cyc();
    chk("ab_fresh_we0", {28'd0, bus.WE_CP, bus.MODE_OUT}, {28'd0, 3'b001, 1'b0});
    drive(1, 16'h0B0B, 0, 0, 0);
    cyc();
    chk("ab_fresh_we1", {13'd0, bus.WR_DATA, bus.WE_CP}, {13'd0, 16'h0B0B, 3'b010});
    drive(0, 16'h0000, 0, 0, 0);
    cyc();
    chk("ab_fresh_start", {30'd0, bus.START, bus.MODE_OUT}, 32'b10);
    cyc();
    drive(0, 16'h0000, 0, 0, 1);
    cyc();
    chk("ab_fresh_done", {30'd0, bus.DONE, bus.BUSY}, 32'b10);
    drive(0, 16'h0000, 0, 0, 0);

    // Asynchronous reset mid-WAIT, away from any clock edge
    drive(1, 16'h3333, 1, 0, 0);
    cyc();
    drive(1, 16'h4444, 1, 0, 0);
    cyc();
    drive(1, 16'h5555, 1, 0, 0);
    cyc();
    drive(0, 16'h0000, 0, 0, 0);
    cyc();
    cyc();
    cyc();
    chk("ar_in_wait", {30'd0, bus.BUSY, bus.MV_READY}, 32'b10);
    #2;
    RST_ASYNC_N = 1'b0;
    #1;
    chk("ar_immediate", outs(), {7'd0, 1'b1, 16'h0000, 3'b000, 5'b00000});
    #2;
    RST_ASYNC_N = 1'b1;
    drive(0, 16'h0000, 0, 0, 1);
    cyc();
    chk("ar_no_done0", {29'd0, bus.DONE, bus.BUSY, bus.MV_READY}, 32'b001);
    drive(0, 16'h0000, 0, 0, 0);
    cyc();
    chk("ar_no_done1", {30'd0, bus.DONE, bus.BUSY}, 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/affine_mv_ctrl.md
# affine_mv_ctrl

Sequencing controller for the control-point motion-vector (CPMV) register bank of the affine motion-compensation datapath. It accepts CPMVs over a valid/ready stream and steers each one into its CPMV register with a one-hot write enable: two CPMVs in 4-parameter mode, three in 6-parameter mode. Once the writes have settled it issues a single START pulse to the affine calculator, then holds off new input until the calculator reports done, the watchdog expires, or the operation is aborted.

## Interface
Parameters:
- MV_W, 16, CPMV width; [MV_W-1:MV_W/2] horizontal, [MV_W/2-1:0] vertical, signed two's complement
- TIMEOUT, 1023, max cycles spent in WAIT before error; counter width = $clog2(TIMEOUT+1)

Ports:
- CLK  in  1  clock, rising edge
- RST_ASYNC_N  in  1  reset, asynchronous, active-low
- MODE_6P  in  1  1 = 6-param (3 CPMVs), 0 = 4-param (2 CPMVs); sampled on first accepted CPMV only
- MV_VALID  in  1  CPMV present on MV_DATA
- MV_DATA  in  MV_W  signed CPMV
- MV_READY  out  1  controller accepts CPMV this cycle
- ABORT  in  1  synchronous cancel, any state
- CALC_DONE  in  1  calculator finished (single-cycle pulse)
- WR_DATA  out  MV_W  registered write bus to CPMV registers
- WE_CP  out  3  registered one-hot write enable, bit i = CPMV register i
- MODE_OUT  out  1  registered mode of current operation
- START  out  1  one-cycle pulse to calculator
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse on CALC_DONE accepted
- ERR  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, LOAD, FLUSH, START, WAIT.
- MV_READY = 1 in IDLE and LOAD, 0 elsewhere (decoded from state).
- Handshake = MV_VALID & MV_READY. On each handshake: WR_DATA <= MV_DATA unmodified; WE_CP <= 1<<idx; idx++. Without a handshake, WE_CP <= 0 and WR_DATA holds its value.
- IDLE: on handshake, latch MODE_OUT <= MODE_6P; idx 0 -> 1; go to LOAD.
- LOAD: accept CPMVs until idx reaches N-1 (N = 3 if MODE_OUT else 2); the handshake with idx == N-1 moves to FLUSH. MV_VALID gaps stall without effect.
- FLUSH: one cycle; the last WE_CP is visible on the outputs. Go to START.
- START: START = 1 for one cycle; clear the watchdog; go to WAIT. A CALC_DONE here is ignored.
- WAIT: on CALC_DONE -> DONE pulse, idx = 0, go to IDLE. Otherwise the watchdog increments; when it reaches TIMEOUT -> ERR pulse, go to IDLE.
- 4-param mode: CPMV register 2 is never written; the calculator uses MODE_OUT to ignore it.
- ABORT in any state: next state IDLE, idx = 0, WE_CP = 0, no START/DONE/ERR. ABORT has priority over handshake, CALC_DONE and timeout in the same cycle.
- CALC_DONE outside WAIT: ignored.
- MODE_6P changes after the first handshake: ignored until the next IDLE.

## Timing
- Reset values: state IDLE, idx 0, WR_DATA 0, WE_CP 000, MODE_OUT 0, START 0, BUSY 0, DONE 0, ERR 0, watchdog 0; MV_READY = 1 immediately after reset.
- Handshake in cycle c -> WE_CP/WR_DATA visible in cycle c+1 -> CPMV register updated at end of c+1.
- Last handshake in cycle c -> FLUSH in c+1, START pulse in c+2. All CPMV registers are valid when START is seen.
- Back-to-back operation: CALC_DONE in cycle d -> IDLE in d+1 with MV_READY = 1; the next first handshake can occur in d+1.
- Minimum period: N load cycles + FLUSH + START + at least 1 WAIT cycle.

## Structure
- Shared package affine_pkg: state enum (IDLE, LOAD, FLUSH, START, WAIT), CP_NUM_4P = 2, CP_NUM_6P = 3, MV_W default.
- One sub-module, mv_watchdog: counter with clear, enable, and expiry compare against TIMEOUT.
- The CPMV registers stay outside this block, instantiated three times at the parent level and driven by WR_DATA/WE_CP.

## Test plan
- 6P, back-to-back CPMVs 0x0102, 0xFF80, 0x7F01 in cycles 0–2 -> WE_CP 001/010/100 in cycles 1–3 with matching WR_DATA, START in cycle 4, MODE_OUT = 1.
- 4P, 0x0A0B then 0xF5F6 with a 3-cycle MV_VALID gap between them -> only WE_CP 001 and 010 asserted, START 2 cycles after second handshake, MODE_OUT = 0, MV_READY = 0 until DONE.
- CALC_DONE asserted during START, then again 5 cycles into WAIT -> first ignored, DONE pulse on the second, IDLE next cycle with MV_READY = 1.
- TIMEOUT = 8, CALC_DONE never asserted -> ERR pulse exactly 8 WAIT cycles after entry, BUSY falls the next cycle.
- ABORT after 2 of 3 CPMVs in 6P mode -> WE_CP 000, no START, IDLE next cycle; a fresh 4P load then completes normally.
- RST_ASYNC_N pulsed low mid-WAIT without a clock edge -> all outputs return to reset values immediately; a later CALC_DONE produces no DONE.
